// File: rtl/pipe_stage.sv
// pipe_stage: skid-buffered pipeline register with flush, ready/valid handshakes and a saturating stall counter
module pipe_stage #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              in_CLK,
  input  logic              in_CLR,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_up_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_dn_ready,
  input  logic              in_FLUSH,
  output logic [CNT_W-1:0]  out_stall_cnt
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc, con;
  always_comb begin
    out_up_ready  = !in_CLR && state_q != SKID;
    out_valid     = state_q != EMPTY;
    out_data      = main_q;
    out_stall_cnt = cnt_q;
    acc           = in_valid && out_up_ready;
    con           = out_valid && in_dn_ready;
    state_d       = state_q;
    main_d        = main_q;
    skid_d        = skid_q;
    cnt_d         = (out_valid && !in_dn_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      EMPTY: begin
        state_d = acc ? FULL : EMPTY;
        main_d  = acc ? in_data : main_q;
      end
      FULL: begin
        state_d = acc ? (con ? FULL : SKID) : (con ? EMPTY : FULL);
        main_d  = acc ? (con ? in_data : main_q) : (con ? NOP_VAL : main_q);
        skid_d  = (acc && !con) ? in_data : skid_q;
      end
      SKID: begin
        state_d = con ? FULL : SKID;
        main_d  = con ? skid_q : main_q;
        skid_d  = con ? NOP_VAL : skid_q;
      end
      default: begin
        state_d = EMPTY;
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
      end
    endcase
    if (in_FLUSH) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end
  end
  always_ff @(posedge in_CLK) begin
    if (in_CLR) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
